// File: rtl/game_state.sv
// Game-flow controller: lives, survival score and invulnerability window, parking the bullet field while idle.
// Optional GAME_STATE_HISCORE_EN adds a hi_score register kept across games until reset.
module game_state #(
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int RESET_HOLD    = 524288,
  parameter int SCORE_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   hit_player,
  input  logic                   start_btn,
  output logic                   bullets_reset,
  output logic [3:0]             lives,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   invuln,
  output logic                   playing,
`ifdef GAME_STATE_HISCORE_EN
  output logic [SCORE_WIDTH-1:0] hi_score,
`endif
  output logic                   game_over
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int INV_W  = $clog2(INVULN_FRAMES + 1);
  localparam logic [HOLD_W-1:0]      HOLD_LOAD  = HOLD_W'(RESET_HOLD - 1);
  localparam logic [INV_W-1:0]       INV_LOAD   = INV_W'(INVULN_FRAMES);
  localparam logic [3:0]             LIVES_LOAD = 4'(START_LIVES);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = '1;

  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_PLAY, ST_HIT, ST_OVER} state_e;

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_ctr_q, hold_ctr_d;
  logic [INV_W-1:0]       inv_ctr_q, inv_ctr_d;
  logic [3:0]             lives_q, lives_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic                   start_prev_q, start_prev_d;
  logic                   bullets_reset_q, bullets_reset_d;
  logic                   invuln_q, invuln_d;
  logic                   playing_q, playing_d;
  logic                   game_over_q, game_over_d;
  logic                   start_rise;
  logic                   score_inc;
`ifdef GAME_STATE_HISCORE_EN
  logic [SCORE_WIDTH-1:0] hi_score_q, hi_score_d;
`endif

  assign start_rise = start_btn & ~start_prev_q;
  assign score_inc  = frame_tick && (score_q != SCORE_MAX);

  always_comb begin
    state_d      = state_q;
    hold_ctr_d   = hold_ctr_q;
    inv_ctr_d    = inv_ctr_q;
    lives_d      = lives_q;
    score_d      = score_q;
    start_prev_d = start_btn;
`ifdef GAME_STATE_HISCORE_EN
    hi_score_d   = hi_score_q;
`endif
    case (state_q)
      ST_IDLE: begin
        lives_d = LIVES_LOAD;
        score_d = '0;
        if (start_rise) begin
          state_d    = ST_ARM;
          hold_ctr_d = HOLD_LOAD;
        end
      end
      ST_ARM: begin
        if (hold_ctr_q == '0) state_d = ST_PLAY;
        else                  hold_ctr_d = hold_ctr_q - HOLD_W'(1);
      end
      ST_PLAY: begin
        if (score_inc) score_d = score_q + SCORE_WIDTH'(1);
        if (hit_player) begin
          if (lives_q == 4'd1) begin
            lives_d = 4'd0;
            state_d = ST_OVER;
`ifdef GAME_STATE_HISCORE_EN
            // score_d already includes a same-cycle tick, so this is the final score
            if (score_d > hi_score_q) hi_score_d = score_d;
`endif
          end else begin
            lives_d   = lives_q - 4'd1;
            inv_ctr_d = INV_LOAD;
            state_d   = ST_HIT;
          end
        end
      end
      ST_HIT: begin
        if (score_inc) score_d = score_q + SCORE_WIDTH'(1);
        if (frame_tick) begin
          inv_ctr_d = inv_ctr_q - INV_W'(1);
          if (inv_ctr_q == INV_W'(1)) state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          state_d    = ST_ARM;
          hold_ctr_d = HOLD_LOAD;
          lives_d    = LIVES_LOAD;
          score_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags are registered copies of the next state's decode.
    bullets_reset_d = (state_d == ST_IDLE) || (state_d == ST_ARM) || (state_d == ST_OVER);
    invuln_d        = (state_d == ST_HIT);
    playing_d       = (state_d == ST_PLAY) || (state_d == ST_HIT);
    game_over_d     = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      hold_ctr_q      <= '0;
      inv_ctr_q       <= '0;
      lives_q         <= LIVES_LOAD;
      score_q         <= '0;
      start_prev_q    <= 1'b1;
      bullets_reset_q <= 1'b1;
      invuln_q        <= 1'b0;
      playing_q       <= 1'b0;
      game_over_q     <= 1'b0;
`ifdef GAME_STATE_HISCORE_EN
      hi_score_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      hold_ctr_q      <= hold_ctr_d;
      inv_ctr_q       <= inv_ctr_d;
      lives_q         <= lives_d;
      score_q         <= score_d;
      start_prev_q    <= start_prev_d;
      bullets_reset_q <= bullets_reset_d;
      invuln_q        <= invuln_d;
      playing_q       <= playing_d;
      game_over_q     <= game_over_d;
`ifdef GAME_STATE_HISCORE_EN
      hi_score_q      <= hi_score_d;
`endif
    end
  end

  assign bullets_reset = bullets_reset_q;
  assign lives         = lives_q;
  assign score         = score_q;
  assign invuln        = invuln_q;
  assign playing       = playing_q;
  assign game_over     = game_over_q;
`ifdef GAME_STATE_HISCORE_EN
  assign hi_score      = hi_score_q;
`endif

endmodule

// File: tb/tb_game_state.sv
// Bench for game_state: directed game scenarios followed by random play, all checked against a game-rules model.
// Define GAME_STATE_HISCORE_EN to also cover hi_score.
module tb_game_state;

  localparam int START_LIVES   = 3;
  localparam int INVULN_FRAMES = 2;
  localparam int RESET_HOLD    = 4;
  localparam int SCORE_WIDTH   = 10;
  localparam int SCORE_MAX     = (1 << SCORE_WIDTH) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk = 1'b0;
  logic                   reset, frame_tick, hit_player, start_btn;
  logic                   bullets_reset, invuln, playing, game_over;
  logic [3:0]             lives;
  logic [SCORE_WIDTH-1:0] score;
`ifdef GAME_STATE_HISCORE_EN
  logic [SCORE_WIDTH-1:0] hi_score;
`endif

  always #5 clk = ~clk;

  game_state #(
    .START_LIVES(START_LIVES), .INVULN_FRAMES(INVULN_FRAMES),
    .RESET_HOLD(RESET_HOLD), .SCORE_WIDTH(SCORE_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .hit_player(hit_player),
    .start_btn(start_btn), .bullets_reset(bullets_reset), .lives(lives),
    .score(score), .invuln(invuln), .playing(playing),
`ifdef GAME_STATE_HISCORE_EN
    .hi_score(hi_score),
`endif
    .game_over(game_over)
  );

  // ---------------- reference model (game rules) ----------------
  bit m_in_lobby;   // waiting for the first start after reset
  bit m_over;
  int m_arm_left;   // clocks of field re-seed still to run
  int m_inv_left;   // frames of invulnerability still to run
  int m_lives, m_score, m_hi;
  bit m_start_prev;

  logic [SCORE_WIDTH-1:0] exp_q[$];  // final scores of games the model ended
  int  errors = 0;
  int  checks = 0;
  bit  over_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit rise;
    rise = start_btn && !m_start_prev;
    m_start_prev = start_btn;
    if (reset) begin
      m_in_lobby = 1; m_over = 0; m_arm_left = 0; m_inv_left = 0;
      m_lives = START_LIVES; m_score = 0; m_hi = 0; m_start_prev = 1;
      exp_q.delete();
    end else if (m_arm_left > 0) begin
      m_arm_left--;
    end else if (m_in_lobby || m_over) begin
      if (rise) begin
        m_in_lobby = 0; m_over = 0; m_arm_left = RESET_HOLD;
        m_lives = START_LIVES; m_score = 0;
      end
    end else begin
      if (frame_tick && m_score < SCORE_MAX) m_score++;
      if (m_inv_left > 0) begin
        if (frame_tick) m_inv_left--;
      end else if (hit_player) begin
        m_lives--;
        if (m_lives == 0) begin
          m_over = 1;
          if (m_score > m_hi) m_hi = m_score;
          exp_q.push_back(SCORE_WIDTH'(m_score));
        end else begin
          m_inv_left = INVULN_FRAMES;
        end
      end
    end
  endtask

  task automatic compare_all();
    bit parked;
    parked = m_in_lobby || m_over || (m_arm_left > 0);
    check("bullets_reset", 32'(bullets_reset), 32'(parked));
    check("playing",       32'(playing),       32'(!parked));
    check("invuln",        32'(invuln),        32'(!parked && m_inv_left > 0));
    check("game_over",     32'(game_over),     32'(m_over));
    check("lives",         32'(lives),         32'(m_lives));
    check("score",         32'(score),         32'(m_score));
`ifdef GAME_STATE_HISCORE_EN
    check("hi_score",      32'(hi_score),      32'(m_hi));
`endif
    // scoreboard: each game the DUT ends must match a game the model ended
    if (game_over === 1'b1 && !over_seen) begin
      over_seen = 1'b1;
      if (exp_q.size() == 0) check("over_unexpected", 32'(score), 32'hFFFF_FFFF);
      else                   check("final_score", 32'(score), 32'(exp_q.pop_front()));
    end else if (game_over !== 1'b1) begin
      over_seen = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_clk();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n, input bit r, input bit t, input bit h, input bit s);
    reset = r; frame_tick = t; hit_player = h; start_btn = s;
    repeat (n) step_clk();
  endtask

  task automatic start_game();
    run(1, 0, 0, 0, 0);
    run(1, 0, 0, 0, 1);
    run(RESET_HOLD, 0, 0, 0, 0);
  endtask

  // Lose all three lives, ending at final_score (final_score >= 4).
  task automatic play_to(input int final_score);
    run(1, 0, 0, 1, 0);
    run(2, 0, 1, 0, 0);
    run(1, 0, 0, 1, 0);
    run(2, 0, 1, 0, 0);
    for (int i = 0; i < final_score - 4; i++) run(1, 0, 1, 0, 0);
    run(1, 0, 0, 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_start_prev = 1;
    run(3, 1, 0, 0, 1);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_score", 32'(score), 32'd0);
    check("rst_bullets_reset", 32'(bullets_reset), 32'd1);

    run(10, 0, 0, 0, 1);
    check("held_btn_idle", 32'(playing), 32'd0);

    run(1, 0, 0, 0, 0);
    run(1, 0, 0, 0, 1);
    run(RESET_HOLD - 1, 0, 0, 0, 1);
    check("arm_last_clock", 32'(bullets_reset), 32'd1);
    run(1, 0, 0, 0, 0);
    check("arm_done_playing", 32'(playing), 32'd1);
    check("arm_done_lives", 32'(lives), 32'd3);
    check("arm_done_score", 32'(score), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run(1, 0, 1, 0, 0);
      run(1, 0, 0, 0, 0);
    end
    check("score_five", 32'(score), 32'd5);

    run(1, 0, 0, 1, 0);
    check("hit_lives", 32'(lives), 32'd2);
    check("hit_invuln", 32'(invuln), 32'd1);
    run(3, 0, 0, 1, 0);
    run(1, 0, 1, 1, 0);
    run(1, 0, 0, 1, 0);
    check("invuln_hits_ignored", 32'(lives), 32'd2);
    run(1, 0, 1, 1, 0);
    check("window_end_invuln", 32'(invuln), 32'd0);
    check("window_end_lives", 32'(lives), 32'd2);
    run(1, 0, 0, 1, 0);
    check("hit_after_window", 32'(lives), 32'd1);
    run(2, 0, 1, 0, 0);
    run(1, 0, 1, 1, 0);
    check("over_lives", 32'(lives), 32'd0);
    check("over_flag", 32'(game_over), 32'd1);
    check("over_score", 32'(score), 32'd10);
    run(5, 0, 1, 1, 0);
    check("over_score_frozen", 32'(score), 32'd10);

    run(1, 0, 0, 0, 0);
    run(1, 0, 0, 0, 1);
    check("restart_lives", 32'(lives), 32'd3);
    check("restart_score", 32'(score), 32'd0);
    check("restart_bullets_reset", 32'(bullets_reset), 32'd1);

    run(RESET_HOLD, 0, 0, 0, 1);
    run(SCORE_MAX + 5, 0, 1, 0, 0);
    check("score_saturate", 32'(score), 32'(SCORE_MAX));

    run(1, 0, 0, 1, 0);
    run(1, 1, 0, 0, 0);
    check("reset_in_hit_invuln", 32'(invuln), 32'd0);
    check("reset_in_hit_lives", 32'(lives), 32'd3);

    start_game();
    play_to(7);
    check("game_a_score", 32'(score), 32'd7);
    start_game();
    play_to(4);
    check("game_b_score", 32'(score), 32'd4);
`ifdef GAME_STATE_HISCORE_EN
    check("hi_score_kept", 32'(hi_score), 32'd7);
`endif

    for (int i = 0; i < 4000; i++)
      run(1, ($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 11) == 0), ($urandom_range(0, 5) == 0));

    check("pending_game_overs", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_state.md
# game_state

Game-flow controller sitting directly downstream of the bullet field. Consumes the registered `hit_player` collision flag and a per-frame tick. Tracks lives, survival score and an invulnerability window. Drives the bullet field's `reset` input so the field is parked while idle or after game over, and re-seeded before each game.

## Interface
Parameters:
- `START_LIVES`, 3: lives loaded at game start; legal range 1..15.
- `INVULN_FRAMES`, 60: frame ticks of invulnerability after a non-fatal hit; must be ≥1.
- `RESET_HOLD`, 524288: clocks `bullets_reset` is held high in ARM. Covers one full bullet movement period (2^19 clocks).
- `SCORE_WIDTH`, 16: score counter width.

Ports:
- `clk`  in  1  system clock; the block's single clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `hit_player`  in  1  collision flag from the bullet field; level, sampled every clock.
- `start_btn`  in  1  start/restart button, active-high level, already debounced.
- `bullets_reset`  out  1  to the bullet field's `reset` input.
- `lives`  out  4  remaining lives.
- `score`  out  SCORE_WIDTH  frames survived in the current game.
- `invuln`  out  1  high during the invulnerability window; used for player blink.
- `playing`  out  1  high in PLAY or HIT.
- `game_over`  out  1  high in OVER.

## Operation
- Start edge: `start_rise = start_btn & ~start_prev`. `start_prev` resets to 1, so a button held through reset does not start a game.
- States: IDLE, ARM, PLAY, HIT, OVER.
- IDLE:
  - Outputs: `bullets_reset`=1, `lives`=START_LIVES, `score`=0.
  - Transition: `start_rise` → ARM.
- ARM:
  - On entry: load `hold_ctr`=RESET_HOLD-1, `lives`=START_LIVES, `score`=0.
  - While in ARM: `bullets_reset`=1; decrement `hold_ctr` every clock.
  - Transition: when `hold_ctr`==0 → PLAY.
  - `start_btn` and `hit_player` are ignored.
- PLAY:
  - `bullets_reset`=0.
  - On `frame_tick`: `score`+1, saturating at all-ones.
  - On `hit_player`=1 with `lives`==1: `lives`=0, → OVER.
  - On `hit_player`=1 with `lives`>1: `lives`-1, load `inv_ctr`=INVULN_FRAMES, → HIT.
- HIT:
  - `invuln`=1; `hit_player` is ignored; score still counts.
  - On `frame_tick`: `inv_ctr`-1. If `inv_ctr` was 1 → PLAY.
- OVER:
  - Outputs: `game_over`=1, `bullets_reset`=1; `score` and `lives` hold.
  - Transition: `start_rise` → ARM.
- `start_btn` is ignored in PLAY and HIT.

## Timing
- All outputs are registered and are combinational functions of state only.
- Reset values: state=IDLE, `bullets_reset`=1, `lives`=START_LIVES, `score`=0, `invuln`=0, `playing`=0, `game_over`=0, `start_prev`=1.
- `reset` overrides everything on the same edge, including mid-ARM or mid-HIT.
- `hit_player` high at edge N in PLAY: `lives`, state and `invuln` update at edge N+1. With the bullet field's own register, this gives 2 clocks from pixel compare to lives change.
- `frame_tick` at edge N: `score` updates at edge N+1.
- `frame_tick` and `hit_player` in the same PLAY cycle: both take effect. Score increments, and the hit is processed.
- Fatal hit with `frame_tick` in the same cycle: score increments once, then freezes in OVER.
- HIT with `inv_ctr`==1, `frame_tick` and `hit_player` together: the hit is ignored and the state → PLAY. A hit on the next clock counts.
- `playing` rises on the ARM→PLAY edge, exactly RESET_HOLD clocks after the `start_rise` edge.
- `bullets_reset` falls on that same edge.

## Configuration
- `GAME_STATE_HISCORE_EN` defined:
  - Adds output `hi_score` [SCORE_WIDTH-1:0], reset to 0.
  - On the PLAY→OVER edge, `hi_score` takes the final score if that score is greater than `hi_score`.
  - `hi_score` is retained across games and cleared only by `reset`.
- Undefined: the `hi_score` port and register do not exist; all other behaviour is identical.

## Test plan
Parameters for all scenarios: START_LIVES=3, INVULN_FRAMES=2, RESET_HOLD=4.
- Start sequence: reset, then `start_btn` 0→1 → `bullets_reset`=1 for exactly 4 clocks, then `playing`=1, `lives`=3, `score`=0.
- Held button: `start_btn` held high through reset and after it → stays IDLE. Release, then press → ARM.
- Scoring: 5 `frame_tick` pulses in PLAY → `score`=5. Preload `score`=0xFFFF plus one tick → stays 0xFFFF.
- Invulnerability window:
  - Hit in PLAY → `lives`=2, `invuln`=1.
  - Further hits before the 2nd tick → `lives` stays 2.
  - After the 2nd tick → `invuln`=0, PLAY.
- Game over: three separated hits → `lives`=0, `game_over`=1, `bullets_reset`=1, score frozen. `start_rise` → ARM with `lives`=3, `score`=0.
- Reset mid-HIT, plus hi-score (with `GAME_STATE_HISCORE_EN`):
  - Reset asserted in HIT → next clock IDLE, `invuln`=0.
  - Game ending at `score`=7, then a game ending at `score`=4 → `hi_score`=7.
